// File: rtl/fetch_controller_pkg.sv
// Shared types for the fetch controller slice.
// State encoding and the NOP word loaded by flushed pipeline registers.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        WAIT_BR,
        HALTED
    } fetch_state_t;

    localparam logic [31:0] NOP_INSN = 32'hD503201F;

endpackage

// File: rtl/fetch_controller_perf_counter.sv
// Free-running event counter that wraps modulo 2^CNT_W.
// Used for branch statistics inside the fetch controller.
module perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// PC / IF-ID sequencing: advance, stall, freeze on branch until EX resolves.
// Also keeps branch statistics and a resolution watchdog.
module fetch_controller
    import fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W     = 64,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                BR_TIMEOUT = 4,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_is_branch,
    input  logic              hazard_stall,
    input  logic              halt_req,
    input  logic              ex_br_valid,
    input  logic              ex_br_taken,
    input  logic [ADDR_W-1:0] ex_br_target,
    input  logic [ADDR_W-1:0] pc_plus4,
    output logic              pc_write_en,
    output logic [ADDR_W-1:0] next_pc,
    output logic              ifid_write_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              halted,
    output logic              br_timeout_err,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  br_taken_count
);

    localparam int WCW = $clog2(BR_TIMEOUT + 1);

    fetch_state_t   state;
    fetch_state_t   stateNext;
    logic [WCW-1:0] waitCnt;
    logic [WCW-1:0] waitNext;
    logic           errSet;
    logic           incBr;
    logic           incTaken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= BOOT;
            waitCnt        <= '0;
            br_timeout_err <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitNext;
            if (errSet) begin
                br_timeout_err <= 1'b1;
            end
        end
    end

    always_comb begin
        stateNext     = state;
        waitNext      = waitCnt;
        errSet        = 1'b0;
        incBr         = 1'b0;
        incTaken      = 1'b0;
        pc_write_en   = 1'b0;
        next_pc       = pc_plus4;
        ifid_write_en = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        halted        = 1'b0;
        unique case (state)
            BOOT: begin
                pc_write_en = 1'b1;
                next_pc     = RESET_PC;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                stateNext   = RUN;
            end
            RUN: begin
                if (halt_req) begin
                    ifid_flush = 1'b1;
                    stateNext  = HALTED;
                end else if (hazard_stall) begin
                    idex_bubble = 1'b1;
                end else if (id_is_branch) begin
                    ifid_flush = 1'b1;
                    waitNext   = WCW'(BR_TIMEOUT);
                    stateNext  = WAIT_BR;
                end else begin
                    pc_write_en   = 1'b1;
                    ifid_write_en = 1'b1;
                end
            end
            WAIT_BR: begin
                ifid_flush = 1'b1;
                if (ex_br_valid && ex_br_taken) begin
                    pc_write_en = 1'b1;
                    next_pc     = ex_br_target;
                    incBr       = 1'b1;
                    incTaken    = 1'b1;
                    stateNext   = RUN;
                end else if (ex_br_valid || waitCnt == WCW'(1)) begin
                    // Watchdog expiry falls through as an uncounted not-taken.
                    pc_write_en   = 1'b1;
                    ifid_write_en = 1'b1;
                    ifid_flush    = 1'b0;
                    incBr         = ex_br_valid;
                    errSet        = !ex_br_valid;
                    stateNext     = RUN;
                end else begin
                    waitNext = waitCnt - WCW'(1);
                end
            end
            HALTED: begin
                ifid_flush = 1'b1;
                halted     = 1'b1;
            end
            default: begin
                stateNext = BOOT;
            end
        endcase
    end

    perf_counter #(.CNT_W(CNT_W)) uBrCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (incBr),
        .count (br_count)
    );

    perf_counter #(.CNT_W(CNT_W)) uTakenCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (incTaken),
        .count (br_taken_count)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed scenarios plus a randomized run against a behavioural model.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_fetch_controller;

    localparam logic [63:0] RST_PC = 64'h0000_0000_0000_1000;
    localparam int          CW     = 4;
    localparam int          TMO    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          idBr, stall, halt, exV, exT;
    logic [63:0]   exTgt, pc4;
    logic          pcWe, ifidWe, flush, bubble, hlt, err;
    logic [63:0]   nextPc;
    logic [CW-1:0] brCnt, tkCnt;

    int total = 0;
    int bad   = 0;
    int eBr   = 0;
    int eTk   = 0;

    always #5 clk = ~clk;

    fetch_controller #(
        .ADDR_W     (64),
        .RESET_PC   (RST_PC),
        .BR_TIMEOUT (TMO),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_is_branch   (idBr),
        .hazard_stall   (stall),
        .halt_req       (halt),
        .ex_br_valid    (exV),
        .ex_br_taken    (exT),
        .ex_br_target   (exTgt),
        .pc_plus4       (pc4),
        .pc_write_en    (pcWe),
        .next_pc        (nextPc),
        .ifid_write_en  (ifidWe),
        .ifid_flush     (flush),
        .idex_bubble    (bubble),
        .halted         (hlt),
        .br_timeout_err (err),
        .br_count       (brCnt),
        .br_taken_count (tkCnt)
    );

    task automatic idleInputs();
        idBr  = 1'b0;
        stall = 1'b0;
        halt  = 1'b0;
        exV   = 1'b0;
        exT   = 1'b0;
        exTgt = '0;
        pc4   = {$urandom, $urandom} & ~64'h3;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic releaseReset();
        nextCycle();
        rst = 1'b0;
        eBr = 0;
        eTk = 0;
    endtask

    task automatic test_reset();
        idleInputs();
        rst = 1'b1;
        #2;
        total++;
        if ({pcWe, flush, bubble, ifidWe, hlt, err} !== 6'b111000) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=111000",
                     {pcWe, flush, bubble, ifidWe, hlt, err});
        end
        total++;
        if (nextPc !== RST_PC || brCnt !== '0 || tkCnt !== '0) begin
            bad++;
            $display("FAIL reset_val pc=%h cnt=%0d/%0d exp pc=%h 0/0",
                     nextPc, brCnt, tkCnt, RST_PC);
        end
        releaseReset();
        @(negedge clk);
        total++;
        if (pcWe !== 1'b1 || nextPc !== RST_PC || ifidWe !== 1'b0) begin
            bad++;
            $display("FAIL boot_cycle we=%b pc=%h ifwe=%b exp 1 %h 0",
                     pcWe, nextPc, ifidWe, RST_PC);
        end
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            idleInputs();
            @(negedge clk);
            total++;
            if ({pcWe, ifidWe, flush, bubble} !== 4'b1100 || nextPc !== pc4) begin
                bad++;
                $display("FAIL idle%0d ctl=%b pc=%h exp 1100 %h",
                         i, {pcWe, ifidWe, flush, bubble}, nextPc, pc4);
            end
            nextCycle();
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            idleInputs();
            stall = 1'b1;
            idBr  = (i == 1);
            @(negedge clk);
            total++;
            if ({pcWe, ifidWe, flush, bubble} !== 4'b0001) begin
                bad++;
                $display("FAIL stall%0d got=%b exp=0001",
                         i, {pcWe, ifidWe, flush, bubble});
            end
            nextCycle();
        end
        idleInputs();
        @(negedge clk);
        total++;
        if ({pcWe, ifidWe, bubble} !== 3'b110) begin
            bad++;
            $display("FAIL stall_resume got=%b exp=110", {pcWe, ifidWe, bubble});
        end
        nextCycle();
    endtask

    task automatic test_taken();
        idleInputs();
        idBr = 1'b1;
        @(negedge clk);
        total++;
        if ({pcWe, ifidWe, flush} !== 3'b001) begin
            bad++;
            $display("FAIL tk_decode got=%b exp=001", {pcWe, ifidWe, flush});
        end
        nextCycle();
        idleInputs();
        exV   = 1'b1;
        exT   = 1'b1;
        exTgt = 64'h40;
        @(negedge clk);
        total++;
        if ({pcWe, ifidWe, flush} !== 3'b101 || nextPc !== 64'h40) begin
            bad++;
            $display("FAIL tk_redirect ctl=%b pc=%h exp 101 40",
                     {pcWe, ifidWe, flush}, nextPc);
        end
        nextCycle();
        eBr++;
        eTk++;
        idleInputs();
        @(negedge clk);
        total++;
        if (brCnt !== CW'(eBr) || tkCnt !== CW'(eTk) || pcWe !== 1'b1) begin
            bad++;
            $display("FAIL tk_count br=%0d tk=%0d we=%b exp %0d %0d 1",
                     brCnt, tkCnt, pcWe, eBr, eTk);
        end
        nextCycle();
    endtask

    task automatic test_not_taken();
        idleInputs();
        idBr = 1'b1;
        exV  = 1'b1;
        exT  = 1'b1;
        @(negedge clk);
        total++;
        if ({pcWe, flush} !== 2'b01) begin
            bad++;
            $display("FAIL nt_decode got=%b exp=01", {pcWe, flush});
        end
        nextCycle();
        idleInputs();
        exV   = 1'b1;
        exTgt = 64'hDEAD_0000;
        @(negedge clk);
        total++;
        if ({pcWe, ifidWe, flush} !== 3'b110 || nextPc !== pc4) begin
            bad++;
            $display("FAIL nt_resume ctl=%b pc=%h exp 110 %h",
                     {pcWe, ifidWe, flush}, nextPc, pc4);
        end
        nextCycle();
        eBr++;
        idleInputs();
        @(negedge clk);
        total++;
        if (brCnt !== CW'(eBr) || tkCnt !== CW'(eTk)) begin
            bad++;
            $display("FAIL nt_count br=%0d tk=%0d exp %0d %0d",
                     brCnt, tkCnt, eBr, eTk);
        end
        nextCycle();
    endtask

    task automatic test_timeout();
        idleInputs();
        idBr = 1'b1;
        nextCycle();
        for (int i = 1; i <= TMO; i++) begin
            idleInputs();
            idBr  = 1'b1;
            stall = 1'b1;
            @(negedge clk);
            total++;
            if (i < TMO && ({pcWe, ifidWe, flush, bubble, err} !== 5'b00100)) begin
                bad++;
                $display("FAIL tmo_wait%0d got=%b exp=00100",
                         i, {pcWe, ifidWe, flush, bubble, err});
            end else if (i == TMO && ({pcWe, ifidWe, flush, err} !== 4'b1100
                                      || nextPc !== pc4)) begin
                bad++;
                $display("FAIL tmo_fire got=%b pc=%h exp 1100 %h",
                         {pcWe, ifidWe, flush, err}, nextPc, pc4);
            end
            nextCycle();
        end
        idleInputs();
        stall = 1'b1;
        @(negedge clk);
        total++;
        if (err !== 1'b1 || bubble !== 1'b1 || brCnt !== CW'(eBr)
            || tkCnt !== CW'(eTk)) begin
            bad++;
            $display("FAIL tmo_after err=%b bub=%b br=%0d tk=%0d exp 1 1 %0d %0d",
                     err, bubble, brCnt, tkCnt, eBr, eTk);
        end
        nextCycle();
    endtask

    task automatic test_halt_in_branch();
        logic [63:0] tgt;
        tgt = {$urandom, $urandom};
        idleInputs();
        idBr = 1'b1;
        nextCycle();
        idleInputs();
        halt  = 1'b1;
        exV   = 1'b1;
        exT   = 1'b1;
        exTgt = tgt;
        @(negedge clk);
        total++;
        if ({pcWe, hlt} !== 2'b10 || nextPc !== tgt) begin
            bad++;
            $display("FAIL halt_resolve ctl=%b pc=%h exp 10 %h",
                     {pcWe, hlt}, nextPc, tgt);
        end
        nextCycle();
        idleInputs();
        halt = 1'b1;
        @(negedge clk);
        total++;
        if ({pcWe, flush, hlt} !== 3'b010) begin
            bad++;
            $display("FAIL halt_run got=%b exp=010", {pcWe, flush, hlt});
        end
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            idleInputs();
            idBr = 1'b1;
            exV  = 1'b1;
            @(negedge clk);
            total++;
            if ({pcWe, ifidWe, flush, hlt} !== 4'b0011) begin
                bad++;
                $display("FAIL halted%0d got=%b exp=0011",
                         i, {pcWe, ifidWe, flush, hlt});
            end
            nextCycle();
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({pcWe, flush, bubble, hlt, err} !== 5'b11100 || brCnt !== '0
            || tkCnt !== '0 || nextPc !== RST_PC) begin
            bad++;
            $display("FAIL halt_reset ctl=%b br=%0d tk=%0d pc=%h",
                     {pcWe, flush, bubble, hlt, err}, brCnt, tkCnt, nextPc);
        end
        releaseReset();
    endtask

    task automatic test_random();
        bit          mStarted, mHalted, mPending, wantErr;
        int          mLeft, mBr, mTk, haltAge;
        logic        eWe, eIf, eFl, eBub;
        logic [63:0] ePc;
        idleInputs();
        rst = 1'b1;
        releaseReset();
        mStarted = 0; mHalted = 0; mPending = 0; wantErr = 0;
        mLeft = 0; mBr = 0; mTk = 0; haltAge = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 99) < 2 || haltAge > 4) begin
                rst = 1'b1;
                #1;
                total++;
                if (err !== 1'b0 || brCnt !== '0 || tkCnt !== '0) begin
                    bad++;
                    $display("FAIL rnd_reset cyc=%0d err=%b br=%0d tk=%0d",
                             cyc, err, brCnt, tkCnt);
                end
                releaseReset();
                mStarted = 0; mHalted = 0; mPending = 0; wantErr = 0;
                mBr = 0; mTk = 0; haltAge = 0;
                continue;
            end
            idBr  = ($urandom_range(0, 99) < 30);
            stall = ($urandom_range(0, 99) < 20);
            halt  = ($urandom_range(0, 99) < 3);
            exV   = ($urandom_range(0, 99) < 40);
            exT   = $urandom_range(0, 1);
            exTgt = {$urandom, $urandom};
            pc4   = {$urandom, $urandom};
            eWe = 0; eIf = 0; eFl = 0; eBub = 0; ePc = pc4;
            @(negedge clk);
            total++;
            if (!mStarted) begin
                eWe = 1; eFl = 1; eBub = 1; ePc = RST_PC;
            end else if (mHalted) begin
                eFl = 1;
            end else if (mPending) begin
                eFl = 1;
                if (exV && exT) begin
                    eWe = 1; ePc = exTgt;
                end else if (exV || mLeft == 1) begin
                    eWe = 1; eIf = 1; eFl = 0;
                end
            end else if (halt) begin
                eFl = 1;
            end else if (stall) begin
                eBub = 1;
            end else if (idBr) begin
                eFl = 1;
            end else begin
                eWe = 1; eIf = 1;
            end
            if ({pcWe, ifidWe, flush, bubble, hlt, err}
                !== {eWe, eIf, eFl, eBub, mHalted, wantErr}
                || nextPc !== ePc || brCnt !== CW'(mBr) || tkCnt !== CW'(mTk)) begin
                bad++;
                $display("FAIL rnd cyc=%0d got=%b/%h/%0d/%0d exp=%b/%h/%0d/%0d",
                         cyc, {pcWe, ifidWe, flush, bubble, hlt, err}, nextPc,
                         brCnt, tkCnt, {eWe, eIf, eFl, eBub, mHalted, wantErr},
                         ePc, CW'(mBr), CW'(mTk));
            end
            if (!mStarted) begin
                mStarted = 1;
            end else if (mHalted) begin
                haltAge++;
            end else if (mPending) begin
                if (exV) begin
                    mBr++;
                    if (exT) mTk++;
                    mPending = 0;
                end else if (mLeft == 1) begin
                    wantErr  = 1;
                    mPending = 0;
                end else begin
                    mLeft--;
                end
            end else if (halt) begin
                mHalted = 1;
            end else if (!stall && idBr) begin
                mPending = 1;
                mLeft    = TMO;
            end
            nextCycle();
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_taken();
        test_not_taken();
        test_timeout();
        test_halt_in_branch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
